i2c_byte_tx: RTL
================

// Module: i2c_byte_tx
// PURPOSE
//  Byte-level I2C transmit stage: accepts one byte over a valid/ready handshake and
//  serialises it MSB-first onto an open-drain SDA. Bits change on SCL fall strobes;
//  SDA is released for the 9th (ACK) bit, which is sampled on SCL rise.
//  Sits between the I2C master controller FSM (byte source) and the SCL generator/pad.
//  Reports done, ACK/NACK and arbitration loss back to the controller.
// PARAMETERS
//  DATA_W     8  bits per transfer (>=2), shifted MSB-first
//  ARB_CHECK  1  1: detect arbitration loss on SCL rise; 0: check disabled
// PORTS
//  clk            in   1       system clock, all logic on rising edge
//  rst            in   1       synchronous, active-high reset
//  tx_data        in   DATA_W  byte to send, captured on handshake
//  tx_valid       in   1       tx_data valid
//  tx_ready       out  1       block can accept a byte (high only in IDLE)
//  scl_fall_tick  in   1       1-cycle strobe: SCL just went low (SDA may change)
//  scl_rise_tick  in   1       1-cycle strobe: SCL just went high (SDA sampling point)
//  sda_in         in   1       synchronised SDA line level
//  sda_oe         out  1       1 = pull SDA low; 0 = release (line floats high)
//  abort          in   1       synchronous abort request from controller
//  busy           out  1       high in any state other than IDLE
//  done           out  1       1-cycle pulse when the ACK bit has been sampled
//  nack           out  1       ACK result, valid from done; held until next handshake
//  arb_lost       out  1       1-cycle pulse: released '1' bit read back as '0'
// BEHAVIOUR
//  Reset: state=IDLE, sda_oe=0, done=0, nack=0, arb_lost=0, busy=0, tx_ready=1.
//  Registers: shreg[DATA_W-1:0], bit_cnt[$clog2(DATA_W)-1:0]; all outputs registered
//   except tx_ready and busy, which decode state.
//  IDLE: tx_ready=1. On tx_valid&tx_ready: shreg<=tx_data, bit_cnt<=DATA_W-1,
//   nack<=0 -> WAIT_LOW. sda_oe stays 0.
//  WAIT_LOW: on scl_fall_tick: sda_oe<=~shreg[MSB] -> DATA.
//  DATA: on scl_rise_tick with ARB_CHECK=1, sda_oe==0 and sda_in==0: arb_lost pulse,
//   sda_oe<=0 -> IDLE (no done). On scl_fall_tick: if bit_cnt==0: sda_oe<=0 -> ACK;
//   else shreg<=shreg<<1, bit_cnt--, sda_oe<=~shreg[MSB-1].
//  ACK: sda_oe=0. On scl_rise_tick: nack<=sda_in, done pulse next cycle -> IDLE.
//  Latency: handshake to first SDA drive = first scl_fall_tick + 1 clk;
//   done asserts 1 clk after the 9th scl_rise_tick after the first bit.
//  scl_fall_tick and scl_rise_tick together: fall wins, rise ignored that cycle.
//  Ticks in IDLE ignored; tx_valid outside IDLE ignored (tx_ready=0).
//  abort (any state but IDLE): sda_oe<=0 -> IDLE next clk, no done/arb_lost;
//   abort beats every other event in the same cycle. abort in IDLE: no effect.
//  rst mid-transfer: same as reset values above; in-flight byte discarded.
//  sda_oe never changes except on scl_fall_tick, abort, arb loss or rst.
// STRUCTURE
//  Shared include i2c_defs.vh: state encodings (IDLE, WAIT_LOW, DATA, ACK, 2-bit),
//   ACK/NACK level constants; reused by the controller FSM and the RX stage.
//  One sub-module: i2c_shift_out (load/shift MSB-first register, DATA_W param,
//   sync active-high rst/clear); FSM, bit counter and ACK/arb logic stay in this top.
// TESTING
//  1. tx_data=0xA5, 9 SCL periods, sda_in follows ~sda_oe, ACK low -> SDA bits
//     1,0,1,0,0,1,0,1; done pulse after 9th rise; nack=0.
//  2. tx_data=0x3C, sda_in high on ACK bit -> nack=1 with done; tx_ready back to 1.
//  3. tx_data=0x80, force sda_in=0 at 2nd bit's rise (bit is '0')... then send
//     0xFF, force sda_in=0 at 3rd rise -> arb_lost pulse, sda_oe=0, no done, IDLE.
//  4. abort asserted during bit 4 of 0x55 -> sda_oe=0 next clk, busy=0, no done;
//     next byte 0x01 sends cleanly.
//  5. rst during ACK of 0xC3 -> all outputs at reset values; ticks in IDLE ignored.
//  6. scl_fall_tick and scl_rise_tick same cycle mid-byte -> one shift only,
//     no sample; tx_valid held during transfer -> not accepted until IDLE.

Source files
------------

// File: rtl/i2c_byte_tx_pkg.sv
// i2c_byte_tx_pkg
// Shared definitions for the I2C byte path: FSM state encodings and the bus
// levels that mean ACK / NACK. The controller FSM and the RX stage import the
// same package, so all three agree on the encodings.
// Ports: none (package).
package i2c_byte_tx_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] S_IDLE     = 2'd0;
    localparam logic [STATE_W-1:0] S_WAIT_LOW = 2'd1;
    localparam logic [STATE_W-1:0] S_DATA     = 2'd2;
    localparam logic [STATE_W-1:0] S_ACK      = 2'd3;

    // SDA level seen by the transmitter during the 9th bit
    localparam logic ACK_LVL  = 1'b0;
    localparam logic NACK_LVL = 1'b1;

endpackage

// File: rtl/i2c_byte_tx_if.sv
// i2c_byte_tx_if
// Bundles the byte handshake, SCL strobes, SDA pad signals and status flags
// between the I2C master controller / SCL generator (master side) and the byte
// transmit stage (slave side).
// Signals:
//   tx_data, tx_valid, tx_ready   byte handshake
//   scl_fall_tick, scl_rise_tick  1-cycle SCL edge strobes
//   sda_in, sda_oe                synchronised SDA level / open-drain pull-down
//   abort                         synchronous abort request
//   busy, done, nack, arb_lost    status back to the controller
interface i2c_byte_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              scl_fall_tick;
    logic              scl_rise_tick;
    logic              sda_in;
    logic              sda_oe;
    logic              abort;
    logic              busy;
    logic              done;
    logic              nack;
    logic              arb_lost;

    modport master (
        output tx_data, tx_valid, scl_fall_tick, scl_rise_tick, sda_in, abort,
        input  tx_ready, sda_oe, busy, done, nack, arb_lost
    );

    modport slave (
        input  tx_data, tx_valid, scl_fall_tick, scl_rise_tick, sda_in, abort,
        output tx_ready, sda_oe, busy, done, nack, arb_lost
    );
endinterface

// File: rtl/i2c_byte_tx_shift_out.sv
// i2c_byte_tx_shift_out
// Load/shift register that presents a word MSB-first. Exposes only the current
// MSB and the bit behind it, which is what the transmitter needs to pre-compute
// the next SDA drive on an SCL fall.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   clear          synchronous clear (in-flight word discarded)
//   load           capture load_data
//   shift          shift left by one (ignored when load is high)
//   load_data      word to capture
//   msb, next_msb  q[DATA_W-1], q[DATA_W-2]
module i2c_byte_tx_shift_out #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] load_data,
    output logic              msb,
    output logic              next_msb
);
    logic [DATA_W-1:0] q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            q <= '0;
        end else if (load) begin
            q <= load_data;
        end else if (shift) begin
            q <= {q[DATA_W-2:0], 1'b0};
        end
    end

    assign msb      = q[DATA_W-1];
    assign next_msb = q[DATA_W-2];
endmodule

// File: rtl/i2c_byte_tx.sv
// i2c_byte_tx
// Byte-level I2C transmit stage. Accepts one byte on a valid/ready handshake,
// drives it MSB-first onto open-drain SDA (changes only on SCL fall strobes),
// releases SDA for the 9th bit and samples ACK/NACK on the following SCL rise.
// Optionally flags arbitration loss when a released '1' reads back as '0'.
// Ports:
//   clk   system clock
//   rst   synchronous active-high reset
//   bus   i2c_byte_tx_if.slave: handshake, SCL strobes, SDA, abort, status
// States:
//   S_IDLE     | waiting for a byte, tx_ready high, SDA released
//   S_WAIT_LOW | byte captured, waiting for SCL low to put out the MSB
//   S_DATA     | data bits on SDA, shifting on each SCL fall
//   S_ACK      | SDA released, waiting for SCL rise to sample ACK
module i2c_byte_tx
    import i2c_byte_tx_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter bit ARB_CHECK = 1'b1
) (
    input logic          clk,
    input logic          rst,
    i2c_byte_tx_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_W);

    logic [STATE_W-1:0] state;
    logic [CNT_W-1:0]   bit_cnt;
    logic               sda_oe;
    logic               done;
    logic               nack;
    logic               arb_lost;
    logic               load;
    logic               shift;
    logic               clear;
    logic               sh_msb;
    logic               sh_next_msb;

    assign load  = (state == S_IDLE) && bus.tx_valid;
    assign shift = (state == S_DATA) && !bus.abort && bus.scl_fall_tick && (bit_cnt != '0);
    assign clear = (state != S_IDLE) && bus.abort;

    i2c_byte_tx_shift_out #(.DATA_W(DATA_W)) u_shift (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .load      (load),
        .shift     (shift),
        .load_data (bus.tx_data),
        .msb       (sh_msb),
        .next_msb  (sh_next_msb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            bit_cnt  <= '0;
            sda_oe   <= 1'b0;
            done     <= 1'b0;
            nack     <= 1'b0;
            arb_lost <= 1'b0;
        end else begin
            done     <= 1'b0;
            arb_lost <= 1'b0;
            if (state == S_IDLE) begin
                if (bus.tx_valid) begin
                    bit_cnt <= CNT_W'(DATA_W - 1);
                    nack    <= 1'b0;
                    state   <= S_WAIT_LOW;
                end
            end else if (bus.abort) begin
                // abort outranks every tick in the same cycle
                sda_oe <= 1'b0;
                state  <= S_IDLE;
            end else begin
                case (state)
                    S_WAIT_LOW: begin
                        if (bus.scl_fall_tick) begin
                            sda_oe <= ~sh_msb;
                            state  <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        // a fall strobe wins over a coincident rise strobe
                        if (bus.scl_fall_tick) begin
                            if (bit_cnt == '0) begin
                                sda_oe <= 1'b0;
                                state  <= S_ACK;
                            end else begin
                                bit_cnt <= bit_cnt - 1'b1;
                                sda_oe  <= ~sh_next_msb;
                            end
                        end else if (bus.scl_rise_tick && ARB_CHECK && !sda_oe && !bus.sda_in) begin
                            arb_lost <= 1'b1;
                            sda_oe   <= 1'b0;
                            state    <= S_IDLE;
                        end
                    end
                    S_ACK: begin
                        if (!bus.scl_fall_tick && bus.scl_rise_tick) begin
                            nack  <= (bus.sda_in == NACK_LVL);
                            done  <= 1'b1;
                            state <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.tx_ready = (state == S_IDLE);
    assign bus.busy     = (state != S_IDLE);
    assign bus.sda_oe   = sda_oe;
    assign bus.done     = done;
    assign bus.nack     = nack;
    assign bus.arb_lost = arb_lost;
endmodule
